// File: rtl/mb_clk_pkg.sv
// rtl/mb_clk_pkg.sv - shared types and default constants for the MB clock pattern generator
//  Contents: clkgen_state_e (IDLE/NORMAL/TRAIN encoding), default SER_W/ON_UI/OFF_UI/ITER.
package mb_clk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    NORMAL = 2'b01,
    TRAIN  = 2'b11
  } clkgen_state_e;

  localparam int DEF_SER_W  = 16;
  localparam int DEF_ON_UI  = 32;
  localparam int DEF_OFF_UI = 16;
  localparam int DEF_ITER   = 128;

endpackage

// File: rtl/mb_clk_pattern_gen_if.sv
// rtl/mb_clk_pattern_gen_if.sv - LTSM request / serializer word bundle for the clock pattern generator
//  Signals: i_start_clk_train, i_ltsm_in_reset (LTSM -> generator);
//           o_ckp_word, o_ckn_word, o_busy, o_done, o_track_word (generator -> serializer/LTSM).
//  o_track_word exists only when MB_CLKGEN_TRACK_EN is defined.
//  Modports: master = generator side, slave = LTSM/serializer side.
interface mb_clk_pattern_gen_if #(
  parameter int SER_W = 16
) ();

  logic             i_start_clk_train;
  logic             i_ltsm_in_reset;
  logic [SER_W-1:0] o_ckp_word;
  logic [SER_W-1:0] o_ckn_word;
  logic             o_busy;
  logic             o_done;
`ifdef MB_CLKGEN_TRACK_EN
  logic [SER_W-1:0] o_track_word;
`endif

  modport master (
    input  i_start_clk_train,
    input  i_ltsm_in_reset,
    output o_ckp_word,
    output o_ckn_word,
    output o_busy,
    output o_done
`ifdef MB_CLKGEN_TRACK_EN
    , output o_track_word
`endif
  );

  modport slave (
    output i_start_clk_train,
    output i_ltsm_in_reset,
    input  o_ckp_word,
    input  o_ckn_word,
    input  o_busy,
    input  o_done
`ifdef MB_CLKGEN_TRACK_EN
    , input o_track_word
`endif
  );

endinterface

// File: rtl/mb_clk_word_lut.sv
// rtl/mb_clk_word_lut.sv - combinational TRAIN word builder for one clock lane polarity
//  Ports: pos_i (UI position of bit0 within the iteration period), last_iter_i (final iteration),
//         word_o (SER_W lane bits, bit0 first). POL=0 builds CKP, POL=1 builds CKN.
module mb_clk_word_lut #(
  parameter int  SER_W  = 16,
  parameter int  ON_UI  = 32,
  parameter int  OFF_UI = 16,
  parameter bit  POL    = 1'b0,
  localparam int PERIOD = ON_UI + OFF_UI,
  localparam int PW     = $clog2(PERIOD)
) (
  input  logic [PW-1:0]    pos_i,
  input  logic             last_iter_i,
  output logic [SER_W-1:0] word_o
);

  localparam logic [PW:0] PERIOD_V = (PW+1)'(PERIOD);
  localparam logic [PW:0] ON_V     = (PW+1)'(ON_UI);

  logic [PW:0] u;
  logic        wrap;
  logic        active;

  always_comb begin
    word_o = '0;
    u      = '0;
    wrap   = 1'b0;
    active = 1'b0;
    for (int k = 0; k < SER_W; k++) begin
      // SER_W <= PERIOD, so a single subtraction folds u back into the period.
      u    = {1'b0, pos_i} + (PW+1)'(k);
      wrap = (u >= PERIOD_V);
      if (wrap) u = u - PERIOD_V;
      // Bits that spill into a new iteration after the final one stay gated.
      active    = (u < ON_V) && !(wrap && last_iter_i);
      word_o[k] = active && (u[0] == POL);
    end
  end

endmodule

// File: rtl/mb_clk_pattern_gen.sv
// rtl/mb_clk_pattern_gen.sv - MB forwarded-clock pattern generator (TRAIN bursts / free-running NORMAL)
//  Ports: i_dig_clk (one word per cycle), i_rst_n (async active-low),
//         bus (mb_clk_pattern_gen_if.master): start/abort requests in, CKP/CKN words, busy, done out.
//  Optional: MB_CLKGEN_TRACK_EN adds o_track_word, a registered copy of o_ckp_word.
module mb_clk_pattern_gen
  import mb_clk_pkg::*;
#(
  parameter int SER_W  = DEF_SER_W,
  parameter int ON_UI  = DEF_ON_UI,
  parameter int OFF_UI = DEF_OFF_UI,
  parameter int ITER   = DEF_ITER
) (
  input  logic                  i_dig_clk,
  input  logic                  i_rst_n,
  mb_clk_pattern_gen_if.master  bus
);

  localparam int PERIOD = ON_UI + OFF_UI;
  localparam int PW     = $clog2(PERIOD);
  localparam int IW     = $clog2(ITER + 1);
  localparam logic [PW:0]      PERIOD_V = (PW+1)'(PERIOD);
  localparam logic [PW:0]      SER_V    = (PW+1)'(SER_W);
  localparam logic [SER_W-1:0] ALT      = {(SER_W/2){2'b01}};

  clkgen_state_e    state_q;
  logic [PW-1:0]    pos_q;
  logic [IW-1:0]    iter_q;
  logic             start_q;
  logic [SER_W-1:0] ckp_q, ckn_q;
  logic [SER_W-1:0] ckp_d, ckn_d;
  logic             busy_q, done_q;
`ifdef MB_CLKGEN_TRACK_EN
  logic [SER_W-1:0] track_q;
`endif

  logic             start_edge, start_drop;
  logic [PW:0]      pos_sum;
  logic             wrap_cross, last_iter;
  logic [PW-1:0]    pos_d;
  logic [SER_W-1:0] lut_ckp, lut_ckn;

  assign start_edge = bus.i_start_clk_train & ~start_q;
  assign start_drop = start_q & ~bus.i_start_clk_train;
  assign pos_sum    = {1'b0, pos_q} + SER_V;
  assign wrap_cross = (pos_sum >= PERIOD_V);
  assign pos_d      = wrap_cross ? PW'(pos_sum - PERIOD_V) : PW'(pos_sum);
  assign last_iter  = (iter_q == IW'(ITER - 1));

  mb_clk_word_lut #(.SER_W(SER_W), .ON_UI(ON_UI), .OFF_UI(OFF_UI), .POL(1'b0)) u_lut_ckp (
    .pos_i(pos_q), .last_iter_i(last_iter), .word_o(lut_ckp)
  );
  mb_clk_word_lut #(.SER_W(SER_W), .ON_UI(ON_UI), .OFF_UI(OFF_UI), .POL(1'b1)) u_lut_ckn (
    .pos_i(pos_q), .last_iter_i(last_iter), .word_o(lut_ckn)
  );

  // Word for the current state; an abort request blanks it in the same cycle.
  always_comb begin
    ckp_d = '0;
    ckn_d = '0;
    if (!bus.i_ltsm_in_reset) begin
      case (state_q)
        TRAIN:   begin ckp_d = lut_ckp; ckn_d = lut_ckn; end
        NORMAL:  begin ckp_d = ALT;     ckn_d = ~ALT;    end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_dig_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      iter_q  <= '0;
      start_q <= 1'b0;
      ckp_q   <= '0;
      ckn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MB_CLKGEN_TRACK_EN
      track_q <= '0;
`endif
    end else begin
      start_q <= bus.i_start_clk_train;
      ckp_q   <= ckp_d;
      ckn_q   <= ckn_d;
`ifdef MB_CLKGEN_TRACK_EN
      track_q <= ckp_d;
`endif
      if (bus.i_ltsm_in_reset) begin
        // Abort leaves o_done as it was.
        state_q <= IDLE;
        pos_q   <= '0;
        iter_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        if (start_edge || start_drop) done_q <= 1'b0;
        case (state_q)
          TRAIN: begin
            busy_q <= 1'b1;
            pos_q  <= pos_d;
            if (wrap_cross) iter_q <= iter_q + 1'b1;
            if (wrap_cross && last_iter) begin
              state_q <= NORMAL;
              done_q  <= 1'b1;
              pos_q   <= '0;
              iter_q  <= '0;
            end
          end
          NORMAL, IDLE: begin
            busy_q <= 1'b0;
            pos_q  <= '0;
            iter_q <= '0;
            if (start_edge) state_q <= TRAIN;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_ckp_word = ckp_q;
  assign bus.o_ckn_word = ckn_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
`ifdef MB_CLKGEN_TRACK_EN
  assign bus.o_track_word = track_q;
`endif

endmodule
